fft_result_reader: RTL and testbench

FFT_RESULT_READER -- requirements
Module: fft_result_reader

---
 rtl/fft_result_reader.sv | 189 ++++++++++++++++++
 tb/tb_fft_result_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// fft_result_reader: streams the final FFT results out of the ping-pong SRAM.
// On a rising edge of i_fft_done it captures the point count and the result
// bank, then issues N SRAM reads. The returned words are buffered in a
// 2-entry FIFO that feeds a valid/ready output port.
// Optional build macro FFT_READER_BITREV_EN: the read address is the index
// bit-reversed over log2(N) bits, so results leave in natural order. Without
// it, the address equals the index and results leave in raw SRAM order.
module fft_result_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_resetn,
  input  logic [2:0]        i_point_configuration,
  input  logic              i_fft_done,
  input  logic              i_sram_read_register,
  output logic              o_sram_rd_en,
  output logic              o_sram_rd_bank,
  output logic [ADDR_W-1:0] o_sram_rd_addr,
  input  logic [DATA_W-1:0] i_sram_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_data_last,
  output logic              o_busy,
  output logic              o_read_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   EIGHT = (ADDR_W+1)'(8);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t state, state_nxt;

  logic              fft_done_q;
  logic              armed;
  logic              start;
  logic [2:0]        cfg_q;
  logic              bank_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_pts;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] addr_map;
  logic              rd_en;
  logic              pop;
  logic              push;
  logic [2:0]        occupancy;

  // Read in flight: SRAM data for it arrives on the following cycle
  logic              vld_p1;
  logic              last_p1;

  // Output FIFO
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;

`ifdef FFT_READER_BITREV_EN
  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] idx_in,
                                                    input logic [2:0]        cfg);
    logic [ADDR_W-1:0] rev;
    rev = {<<{idx_in}};
    // Full-width reversal parks the result in the top bits; shift it down to log2(N) bits.
    return rev >> (ADDR_W - 3 - int'(cfg));
  endfunction
`endif

  // armed stays low for the first cycle after reset so a level already high
  // at reset release is absorbed into fft_done_q instead of looking like an edge.
  assign start    = armed && i_fft_done && !fft_done_q;
  assign n_pts    = EIGHT << cfg_q;
  assign last_idx = n_pts[ADDR_W-1:0] - ONE_A;

`ifdef FFT_READER_BITREV_EN
  assign addr_map = bit_reverse(idx, cfg_q);
`else
  assign addr_map = idx;
`endif

  // A word leaving the FIFO this cycle frees its slot, which keeps 1 word/cycle.
  assign o_data_valid = (fifo_count != 2'd0);
  assign pop          = o_data_valid && i_data_ready;
  assign push         = vld_p1;
  assign occupancy    = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
  assign rd_en        = (state == READ) && (occupancy < 3'd2);

  assign o_sram_rd_en   = rd_en;
  assign o_sram_rd_bank = rd_en && bank_q;
  assign o_sram_rd_addr = rd_en ? addr_map : '0;
  assign o_data         = o_data_valid ? fifo_data[rd_ptr] : '0;
  assign o_data_last    = o_data_valid && fifo_last[rd_ptr];

  // Edge detector for i_fft_done plus the post-reset arming flag
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      fft_done_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      fft_done_q <= i_fft_done;
      armed      <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_nxt   = state;
    o_busy      = 1'b0;
    o_read_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        o_busy = 1'b1;
        if (rd_en && (idx == last_idx)) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (pop && o_data_last) state_nxt = DONE;
      end
      DONE: begin
        o_read_done = 1'b1;
        if (!i_fft_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture configuration at stream start and advance the read index per issued read
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      cfg_q  <= 3'd0;
      bank_q <= 1'b0;
      idx    <= '0;
    end else if ((state == IDLE) && start) begin
      cfg_q  <= i_point_configuration;
      bank_q <= i_sram_read_register;
      idx    <= '0;
    end else if (rd_en) begin
      idx <= idx + ONE_A;
    end
  end

  // In-flight valid; cleared by reset so data returning for an aborted read is dropped
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) vld_p1 <= 1'b0;
    else           vld_p1 <= rd_en;
  end

  // In-flight last marker travels with vld_p1
  always_ff @(posedge clk) begin
    last_p1 <= rd_en && (idx == last_idx);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage, written when the SRAM word for the in-flight read returns
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= i_sram_rd_data;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader. The SRAM model returns
// {bank at bit 16, address} one cycle after each read strobe.
module tb_fft_result_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              i_resetn;
  logic [2:0]        i_point_configuration;
  logic              i_fft_done;
  logic              i_sram_read_register;
  logic              o_sram_rd_en;
  logic              o_sram_rd_bank;
  logic [ADDR_W-1:0] o_sram_rd_addr;
  logic [DATA_W-1:0] i_sram_rd_data;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              i_data_ready;
  logic              o_data_last;
  logic              o_busy;
  logic              o_read_done;

  fft_result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk                   (clk),
    .i_resetn              (i_resetn),
    .i_point_configuration (i_point_configuration),
    .i_fft_done            (i_fft_done),
    .i_sram_read_register  (i_sram_read_register),
    .o_sram_rd_en          (o_sram_rd_en),
    .o_sram_rd_bank        (o_sram_rd_bank),
    .o_sram_rd_addr        (o_sram_rd_addr),
    .i_sram_rd_data        (i_sram_rd_data),
    .o_data                (o_data),
    .o_data_valid          (o_data_valid),
    .i_data_ready          (i_data_ready),
    .o_data_last           (o_data_last),
    .o_busy                (o_busy),
    .o_read_done           (o_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, garbage when no read was issued
  always @(posedge clk) begin
    if (o_sram_rd_en) i_sram_rd_data <= {15'd0, o_sram_rd_bank, 6'd0, o_sram_rd_addr};
    else              i_sram_rd_data <= 32'hDEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] got_data[$];
  bit                got_last[$];
  int first_valid_cyc, busy_cyc, last_xfer_cyc, done_cyc, issued, accepted;
  bit stall_bad, occ_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i, input int cfg, input int bank);
    int a;
    a = i;
`ifdef FFT_READER_BITREV_EN
    a = 0;
    for (int b = 0; b < cfg + 3; b++)
      if ((i >> b) & 1) a = a | (1 << (cfg + 2 - b));
`endif
    return 32'((bank << 16) | a);
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rd_en"},   32'(o_sram_rd_en),   0);
    chk({tag, "_rd_bank"}, 32'(o_sram_rd_bank), 0);
    chk({tag, "_rd_addr"}, 32'(o_sram_rd_addr), 0);
    chk({tag, "_data"},    o_data,              0);
    chk({tag, "_valid"},   32'(o_data_valid),   0);
    chk({tag, "_last"},    32'(o_data_last),    0);
    chk({tag, "_busy"},    32'(o_busy),         0);
    chk({tag, "_done"},    32'(o_read_done),    0);
  endtask

  // Runs cycle by cycle from the negedge after a start, recording transfers.
  // stop_after > 0 stops once that many words were accepted; drop_at >= 0
  // lowers i_fft_done once that many words were accepted.
  task automatic collect(input int stop_after, input bit rand_ready, input int budget,
                         input int drop_at);
    logic [DATA_W-1:0] held_d;
    bit held_l;
    bit stalled;
    got_data.delete();
    got_last.delete();
    first_valid_cyc = -1; busy_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    issued = 0; accepted = 0; stall_bad = 0; occ_bad = 0;
    stalled = 0; held_d = '0; held_l = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      i_data_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (drop_at >= 0 && accepted >= drop_at) i_fft_done = 1'b0;
      #1;
      if (o_busy && busy_cyc < 0) busy_cyc = k;
      if (o_read_done) begin
        done_cyc = k;
        break;
      end
      if (o_data_valid && first_valid_cyc < 0) first_valid_cyc = k;
      if (stalled && (!o_data_valid || o_data !== held_d || o_data_last !== held_l))
        stall_bad = 1;
      if (o_sram_rd_en) issued++;
      if (o_data_valid && i_data_ready) begin
        got_data.push_back(o_data);
        got_last.push_back(o_data_last);
        accepted++;
        last_xfer_cyc = k;
        stalled = 0;
      end else if (o_data_valid) begin
        stalled = 1;
        held_d = o_data;
        held_l = o_data_last;
      end else begin
        stalled = 0;
      end
      if (issued - accepted > 2) occ_bad = 1;
      if (stop_after > 0 && accepted >= stop_after) break;
    end
  endtask

  task automatic verify_stream(input string tag, input int cfg, input int bank);
    int n, bad, lbad;
    n = 8 << cfg;
    bad = 0;
    lbad = 0;
    chk({tag, "_count"}, got_data.size(), n);
    for (int i = 0; i < got_data.size(); i++) begin
      if (got_data[i] !== exp_word(i, cfg, bank)) bad++;
      if (got_last[i] !== (i == n - 1)) lbad++;
    end
    chk({tag, "_data_errs"}, bad, 0);
    chk({tag, "_last_errs"}, lbad, 0);
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
  endtask

  int tbl[8];

  initial begin
`ifdef FFT_READER_BITREV_EN
    tbl = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    tbl = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    i_resetn = 1'b0;
    i_fft_done = 1'b1;
    i_data_ready = 1'b0;
    i_point_configuration = 3'd0;
    i_sram_read_register = 1'b0;

    // reset state, with i_fft_done already high
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    i_resetn = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("no_start_level_busy", 32'(o_busy), 0);
    chk("no_start_level_rden", 32'(o_sram_rd_en), 0);

    // cfg=0, bank 0, ready high
    i_fft_done = 1'b0;
    @(negedge clk);
    i_point_configuration = 3'd0;
    i_sram_read_register = 1'b0;
    i_fft_done = 1'b1;
    collect(0, 0, 100, -1);
    verify_stream("cfg0", 0, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("cfg0_word%0d", i), (i < got_data.size()) ? got_data[i] : 32'hFFFF_FFFF,
          32'(tbl[i]));
    chk("cfg0_first_valid_lat", 32'(first_valid_cyc - busy_cyc), 2);
    chk("cfg0_done_after_last", 32'(done_cyc - last_xfer_cyc), 1);

    // i_fft_done held high in DONE: no restart
    repeat (3) @(negedge clk);
    #1;
    chk("hold_done_flag", 32'(o_read_done), 1);
    chk("hold_no_restart", 32'(o_busy), 0);
    i_fft_done = 1'b0;
    @(negedge clk);
    #1;
    chk("done_to_idle", 32'(o_read_done), 0);

    // second stream: bank 1 captured at start, later input changes ignored
    i_sram_read_register = 1'b1;
    i_fft_done = 1'b1;
    @(negedge clk);
    i_sram_read_register = 1'b0;
    i_point_configuration = 3'd3;
    collect(0, 0, 100, -1);
    verify_stream("restart_bank1", 0, 1);

    // cfg=7, 1024 words back to back
    i_fft_done = 1'b0;
    @(negedge clk);
    i_point_configuration = 3'd7;
    i_sram_read_register = 1'b1;
    i_fft_done = 1'b1;
    collect(0, 0, 1200, -1);
    verify_stream("cfg7", 7, 1);
    chk("cfg7_no_gaps", 32'(last_xfer_cyc - first_valid_cyc), 1023);
    chk("cfg7_done_cycle", 32'(done_cyc - first_valid_cyc), 1024);

    // cfg=2, random ready, i_fft_done dropped mid-stream
    i_fft_done = 1'b0;
    @(negedge clk);
    i_point_configuration = 3'd2;
    i_sram_read_register = 1'b0;
    i_fft_done = 1'b1;
    collect(0, 1, 400, 10);
    verify_stream("cfg2_stall", 2, 0);
    chk("cfg2_stall_stable", 32'(stall_bad), 0);
    chk("cfg2_outstanding_le2", 32'(occ_bad), 0);
    @(negedge clk);
    #1;
    chk("cfg2_done_to_idle", 32'(o_read_done), 0);
    chk("cfg2_idle_busy", 32'(o_busy), 0);

    // reset at word 5 of 16, then restart
    i_point_configuration = 3'd1;
    i_fft_done = 1'b1;
    collect(5, 0, 100, -1);
    chk("pre_reset_words", accepted, 5);
    i_resetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    i_resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_reset_no_start", 32'(o_busy), 0);
    i_fft_done = 1'b0;
    @(negedge clk);
    i_fft_done = 1'b1;
    collect(0, 0, 100, -1);
    verify_stream("after_reset", 1, 0);
    chk("after_reset_first", (got_data.size() > 0) ? got_data[0] : 32'hFFFF_FFFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
